// File: rtl/wgt_pingpong_loader.sv
// rtl/wgt_pingpong_loader.sv - double-buffered weight matrix and attention vector loader
module wgt_pingpong_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FEAT_IN   = 1433,
  parameter int NUM_COLS      = 16,
  parameter int SRC_ADDR_W    = 15,
  localparam int ROW_W        = $clog2(MAX_FEAT_IN + 1),
  localparam int RADDR_W      = $clog2(MAX_FEAT_IN),
  localparam int A_DEPTH      = 2 * NUM_COLS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_start_i,
  input  logic [SRC_ADDR_W-1:0]            load_base_i,
  input  logic [ROW_W-1:0]                 load_rows_i,
  output logic                             load_rdy_o,
  output logic                             load_busy_o,
  output logic                             src_en_o,
  output logic [SRC_ADDR_W-1:0]            src_addr_o,
  input  logic [DATA_WIDTH-1:0]            src_dout_i,
  input  logic [NUM_COLS*RADDR_W-1:0]      mult_addr_i,
  output logic [NUM_COLS*DATA_WIDTH-1:0]   mult_dout_o,
  output logic [A_DEPTH*DATA_WIDTH-1:0]    a_o,
  output logic                             w_rdy_o,
  output logic                             rd_bank_o,
  input  logic                             release_i
);

  localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int AIDX_W = $clog2(A_DEPTH);
  localparam int CNT_W  = $clog2(MAX_FEAT_IN * NUM_COLS + A_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                          state_q, state_d;
  logic                            src_en_q, src_en_d;
  logic [SRC_ADDR_W-1:0]           src_addr_q, src_addr_d;
  logic [CNT_W-1:0]                left_q, left_d;
  logic                            busy_q, busy_d;
  logic                            rdy_q, rdy_d;
  logic                            w_rdy_q, w_rdy_d;
  logic [1:0]                      full_q, full_d;
  logic                            wr_ptr_q, wr_ptr_d;
  logic                            rd_ptr_q, rd_ptr_d;
  logic                            wr_vld_q, wr_vld_d;
  logic [ROW_W-1:0]                rows_q, rows_d;
  logic [RADDR_W-1:0]              wrow_q, wrow_d;
  logic [COL_W-1:0]                wcol_q, wcol_d;
  logic [AIDX_W-1:0]               aidx_q, aidx_d;
  logic                            in_a_q, in_a_d;
  logic [DATA_WIDTH-1:0]           a_regs_q [2][A_DEPTH];
  logic [DATA_WIDTH-1:0]           a_regs_d [2][A_DEPTH];
  logic [A_DEPTH*DATA_WIDTH-1:0]   a_o_q, a_o_d;
  logic [NUM_COLS*DATA_WIDTH-1:0]  mult_dout_q, mult_dout_d;

  logic [DATA_WIDTH-1:0]           col_mem [2][NUM_COLS][MAX_FEAT_IN];

  logic [ROW_W-1:0]                rows_clamp;
  logic [CNT_W-1:0]                n_total;
  logic                            w_we;
  logic                            done;

  assign rows_clamp = (load_rows_i > ROW_W'(MAX_FEAT_IN)) ? ROW_W'(MAX_FEAT_IN) : load_rows_i;
  assign n_total    = CNT_W'(rows_clamp) * CNT_W'(NUM_COLS) + CNT_W'(A_DEPTH);
  assign w_we       = wr_vld_q & ~in_a_q;
  assign done       = wr_vld_q & in_a_q & (aidx_q == AIDX_W'(A_DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    src_en_d   = src_en_q;
    src_addr_d = src_addr_q;
    left_d     = left_q;
    busy_d     = busy_q;
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rows_d     = rows_q;
    wrow_d     = wrow_q;
    wcol_d     = wcol_q;
    aidx_d     = aidx_q;
    in_a_d     = in_a_q;
    a_regs_d   = a_regs_q;
    a_o_d      = a_o_q;
    wr_vld_d   = src_en_q;

    // Write side trails the read issue by the BRAM latency; row/col walk then attention slots.
    if (wr_vld_q) begin
      if (in_a_q) begin
        a_regs_d[wr_ptr_q][aidx_q] = src_dout_i;
        aidx_d = aidx_q + AIDX_W'(1);
      end else if (wcol_q == COL_W'(NUM_COLS - 1)) begin
        wcol_d = '0;
        if (ROW_W'(wrow_q) + ROW_W'(1) == rows_q) begin
          in_a_d = 1'b1;
        end else begin
          wrow_d = wrow_q + RADDR_W'(1);
        end
      end else begin
        wcol_d = wcol_q + COL_W'(1);
      end
    end

    if (done) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
      busy_d           = 1'b0;
    end

    // Completion targets the write bank, release the read bank; they never collide.
    if (release_i && w_rdy_q) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (load_start_i && rdy_q) begin
          state_d    = ISSUE;
          src_en_d   = 1'b1;
          src_addr_d = load_base_i;
          left_d     = n_total - CNT_W'(1);
          busy_d     = 1'b1;
          rows_d     = rows_clamp;
          wrow_d     = '0;
          wcol_d     = '0;
          aidx_d     = '0;
          in_a_d     = (rows_clamp == '0);
        end
      end
      ISSUE: begin
        if (left_q == '0) begin
          src_en_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          src_addr_d = src_addr_q + SRC_ADDR_W'(1);
          left_d     = left_q - CNT_W'(1);
        end
      end
      DRAIN: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d   = (state_d == IDLE) && !full_d[wr_ptr_d];
    w_rdy_d = full_d[rd_ptr_d];

    for (int i = 0; i < A_DEPTH; i++) begin
      a_o_d[i*DATA_WIDTH +: DATA_WIDTH] = a_regs_d[rd_ptr_d][i];
    end
  end

  always_comb begin
    mult_dout_d = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      mult_dout_d[c*DATA_WIDTH +: DATA_WIDTH] = col_mem[rd_ptr_q][c][mult_addr_i[c*RADDR_W +: RADDR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      col_mem[wr_ptr_q][wcol_q][wrow_q] <= src_dout_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_en_q    <= 1'b0;
      src_addr_q  <= '0;
      left_q      <= '0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b0;
      w_rdy_q     <= 1'b0;
      full_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_vld_q    <= 1'b0;
      rows_q      <= '0;
      wrow_q      <= '0;
      wcol_q      <= '0;
      aidx_q      <= '0;
      in_a_q      <= 1'b0;
      a_o_q       <= '0;
      mult_dout_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < A_DEPTH; i++) begin
          a_regs_q[b][i] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      src_en_q    <= src_en_d;
      src_addr_q  <= src_addr_d;
      left_q      <= left_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
      w_rdy_q     <= w_rdy_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_vld_q    <= wr_vld_d;
      rows_q      <= rows_d;
      wrow_q      <= wrow_d;
      wcol_q      <= wcol_d;
      aidx_q      <= aidx_d;
      in_a_q      <= in_a_d;
      a_o_q       <= a_o_d;
      mult_dout_q <= mult_dout_d;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < A_DEPTH; i++) begin
          a_regs_q[b][i] <= a_regs_d[b][i];
        end
      end
    end
  end

  assign load_rdy_o  = rdy_q;
  assign load_busy_o = busy_q;
  assign src_en_o    = src_en_q;
  assign src_addr_o  = src_addr_q;
  assign w_rdy_o     = w_rdy_q;
  assign rd_bank_o   = rd_ptr_q;
  assign a_o         = a_o_q;
  assign mult_dout_o = mult_dout_q;

endmodule

// File: tb/tb_wgt_pingpong_loader.sv
// tb/tb_wgt_pingpong_loader.sv - randomized check of wgt_pingpong_loader against a transaction-level model
module tb_wgt_pingpong_loader;
  localparam int DW      = 8;
  localparam int MAXF    = 8;
  localparam int NC      = 4;
  localparam int SAW     = 15;
  localparam int ROW_W   = 4;
  localparam int RADDR_W = 3;
  localparam int AD      = 8;
  localparam int MA_W    = NC * RADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start_i = 1'b0;
  logic [SAW-1:0] load_base_i = '0;
  logic [ROW_W-1:0] load_rows_i = '0;
  logic load_rdy_o, load_busy_o, src_en_o, w_rdy_o, rd_bank_o;
  logic [SAW-1:0] src_addr_o;
  logic [DW-1:0] src_dout_i = '0;
  logic [MA_W-1:0] mult_addr_i = '0;
  logic [NC*DW-1:0] mult_dout_o;
  logic [AD*DW-1:0] a_o;
  logic release_i = 1'b0;
  logic [7:0] salt = 8'd0;

  int vectors = 0;
  int miscompares = 0;
  int tb_cyc = 0;
  int en_total = 0;
  logic [SAW-1:0] en_first = '0, en_last = '0;
  logic en_prev = 1'b0;

  wgt_pingpong_loader #(.DATA_WIDTH(DW), .MAX_FEAT_IN(MAXF), .NUM_COLS(NC), .SRC_ADDR_W(SAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(load_start_i), .load_base_i(load_base_i), .load_rows_i(load_rows_i),
    .load_rdy_o(load_rdy_o), .load_busy_o(load_busy_o),
    .src_en_o(src_en_o), .src_addr_o(src_addr_o), .src_dout_i(src_dout_i),
    .mult_addr_i(mult_addr_i), .mult_dout_o(mult_dout_o), .a_o(a_o),
    .w_rdy_o(w_rdy_o), .rd_bank_o(rd_bank_o), .release_i(release_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (src_en_o) src_dout_i <= src_addr_o[7:0] ^ salt;
  end

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: bank contents, full flags, pointers and the issue schedule of the active load.
  int m_cyc = 0, m_e0 = 0, m_n = 0, m_r = 0;
  bit m_active = 0;
  logic [SAW-1:0] m_base = '0;
  logic [7:0] m_salt = '0;
  bit m_full [2];
  bit m_wr = 0, m_rd = 0;
  logic [7:0] m_w [2][MAXF][NC];
  bit m_known [2][MAXF];
  logic [7:0] m_a [2][AD];
  bit e_rdy = 0, e_busy = 0, e_en = 0, e_wrdy = 0, e_rdbank = 0;
  logic [SAW-1:0] e_addr = '0;
  logic [NC*DW-1:0] e_mult = '0;
  logic [NC-1:0] e_mult_chk = '0;

  initial begin
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 0;
      for (int r = 0; r < MAXF; r++) m_known[b][r] = 0;
    end
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      if (m_active) for (int r = 0; r < MAXF; r++) m_known[m_wr][r] = 0;
      m_active = 0; m_full[0] = 0; m_full[1] = 0; m_wr = 0; m_rd = 0;
      e_rdy = 0; e_busy = 0; e_en = 0; e_wrdy = 0; e_rdbank = 0; e_mult_chk = '0;
    end else begin
      logic [RADDR_W-1:0] ra;
      logic [SAW-1:0] ad;
      logic [7:0] d;
      m_cyc++;
      for (int c = 0; c < NC; c++) begin
        ra = mult_addr_i[c*RADDR_W +: RADDR_W];
        e_mult_chk[c] = e_wrdy && m_known[m_rd][ra];
        e_mult[c*DW +: DW] = m_w[m_rd][ra][c];
      end
      if (release_i && e_wrdy) begin
        m_full[m_rd] = 0;
        m_rd = !m_rd;
      end
      if (m_active && m_cyc == m_e0 + m_n + 1) begin
        for (int k = 0; k < m_n; k++) begin
          ad = m_base + SAW'(k);
          d = ad[7:0] ^ m_salt;
          if (k < m_r * NC) m_w[m_wr][k / NC][k % NC] = d;
          else m_a[m_wr][k - m_r * NC] = d;
        end
        for (int r = 0; r < m_r; r++) m_known[m_wr][r] = 1;
        m_full[m_wr] = 1;
        m_wr = !m_wr;
        m_active = 0;
      end
      if (load_start_i && e_rdy) begin
        m_active = 1;
        m_e0 = m_cyc;
        m_r = (int'(load_rows_i) > MAXF) ? MAXF : int'(load_rows_i);
        m_n = m_r * NC + AD;
        m_base = load_base_i;
        m_salt = salt;
      end
      e_rdy = !m_active && !m_full[m_wr];
      e_busy = m_active;
      e_en = m_active && ((m_cyc - m_e0) < m_n);
      e_addr = m_base + SAW'(m_cyc - m_e0);
      e_wrdy = m_full[m_rd];
      e_rdbank = m_rd;
    end
  end

  logic [AD*DW-1:0] ea;
  initial forever begin
    @(negedge clk);
    if (src_en_o) begin
      if (!en_prev) en_first = src_addr_o;
      en_last = src_addr_o;
      en_total++;
    end
    en_prev = src_en_o;
    if (!rst_n) begin
      chk("rst_src_en", src_en_o, 0);
      chk("rst_busy", load_busy_o, 0);
      chk("rst_w_rdy", w_rdy_o, 0);
      chk("rst_rd_bank", rd_bank_o, 0);
      chk("rst_load_rdy", load_rdy_o, 0);
    end else begin
      chk("load_rdy", load_rdy_o, e_rdy);
      chk("load_busy", load_busy_o, e_busy);
      chk("src_en", src_en_o, e_en);
      chk("w_rdy", w_rdy_o, e_wrdy);
      chk("rd_bank", rd_bank_o, e_rdbank);
      if (e_en) chk("src_addr", src_addr_o, e_addr);
      if (e_wrdy) begin
        for (int i = 0; i < AD; i++) ea[i*DW +: DW] = m_a[m_rd][i];
        chk("a_o", a_o, ea);
      end
      for (int c = 0; c < NC; c++) begin
        if (e_mult_chk[c]) chk("mult_dout", 64'(mult_dout_o[c*DW +: DW]), 64'(e_mult[c*DW +: DW]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; load_start_i = 1'b0; release_i = 1'b0; mult_addr_i = '0; salt = 8'd0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_load(input int base, input int rows, output int e0);
    int g;
    g = 0;
    while (!load_rdy_o && g < 200) begin step(); g++; end
    chk("start_rdy", load_rdy_o, 1);
    load_start_i = 1'b1;
    load_base_i = SAW'(base);
    load_rows_i = ROW_W'(rows);
    step();
    e0 = tb_cyc;
    load_start_i = 1'b0;
  endtask

  task automatic wait_wrdy();
    int g;
    g = 0;
    while (!w_rdy_o && g < 200) begin step(); g++; end
  endtask

  int e0, en0, g;

  initial begin
    // Load of 3 rows at base 100: 20 reads, then bank 0 becomes readable.
    apply_reset();
    chk("reset_load_rdy", load_rdy_o, 1);
    chk("reset_w_rdy", w_rdy_o, 0);
    chk("reset_rd_bank", rd_bank_o, 0);
    en0 = en_total;
    start_load(100, 3, e0);
    wait_wrdy();
    chk("s1_w_rdy", w_rdy_o, 1);
    chk("s1_w_rdy_latency", tb_cyc - e0, 21);
    chk("s1_read_count", en_total - en0, 20);
    chk("s1_first_addr", en_first, 100);
    chk("s1_last_addr", en_last, 119);
    mult_addr_i = {3'd0, 3'd1, 3'd0, 3'd0};
    step();
    chk("s1_lane2_row1", mult_dout_o[23:16], 106);
    chk("s1_a0", a_o[7:0], 112);
    chk("s1_a7", a_o[63:56], 119);

    // Two back-to-back loads fill both banks; a third start is ignored.
    apply_reset();
    start_load(0, 0, e0);
    wait_wrdy();
    start_load(200, 0, e0);
    g = 0;
    while (load_busy_o && g < 200) begin step(); g++; end
    chk("s2_busy_done", load_busy_o, 0);
    chk("s2_load_rdy_low", load_rdy_o, 0);
    chk("s2_a0_bank0", a_o[7:0], 0);
    en0 = en_total;
    load_start_i = 1'b1; load_base_i = SAW'(400);
    repeat (5) step();
    load_start_i = 1'b0;
    step();
    chk("s2_third_ignored", en_total - en0, 0);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    chk("s2_rd_bank", rd_bank_o, 1);
    chk("s2_w_rdy", w_rdy_o, 1);
    chk("s2_a0_bank1", a_o[7:0], 200);

    // rows=0 then rows=12 clamped to 8; release lands on the second load's final write edge.
    apply_reset();
    en0 = en_total;
    start_load(300, 0, e0);
    wait_wrdy();
    chk("s3_rows0_reads", en_total - en0, 8);
    en0 = en_total;
    start_load(500, 12, e0);
    repeat (40) step();
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    chk("s3_clamped_reads", en_total - en0, 40);
    chk("s4_w_rdy", w_rdy_o, 1);
    chk("s4_rd_bank", rd_bank_o, 1);
    chk("s4_load_rdy", load_rdy_o, 1);

    // Asynchronous reset mid-load, ignored release, then a fresh load.
    apply_reset();
    start_load(50, 3, e0);
    repeat (10) step();
    #1 rst_n = 1'b0;
    #1;
    chk("s5_src_en", src_en_o, 0);
    chk("s5_src_addr", src_addr_o, 0);
    chk("s5_busy", load_busy_o, 0);
    chk("s5_load_rdy", load_rdy_o, 0);
    chk("s5_a_o", a_o, 0);
    chk("s5_mult_dout", mult_dout_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("s5_post_w_rdy", w_rdy_o, 0);
    chk("s5_post_load_rdy", load_rdy_o, 1);
    release_i = 1'b1;
    step();
    release_i = 1'b0;
    step();
    chk("s6_rd_bank_kept", rd_bank_o, 0);
    chk("s6_w_rdy_kept", w_rdy_o, 0);
    start_load(60, 2, e0);
    wait_wrdy();
    chk("s5_fresh_w_rdy", w_rdy_o, 1);
    chk("s5_fresh_a0", a_o[7:0], 68);

    // Randomized traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      load_start_i = ($urandom_range(0, 3) == 0);
      load_base_i = SAW'($urandom);
      load_rows_i = ROW_W'($urandom_range(0, 12));
      release_i = ($urandom_range(0, 7) == 0);
      mult_addr_i = MA_W'($urandom);
      if (!load_busy_o && !src_en_o && $urandom_range(0, 9) == 0) begin
        salt = 8'($urandom);
        load_start_i = 1'b0;
      end
      step();
    end
    load_start_i = 1'b0;
    release_i = 1'b0;
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
